// File: rtl/vga_pixel_drive.sv
// Serialises a 24-bit pixel onto a 12-bit DAC bus as two registered halves
// at 2x pixel clock. hsync gates the drive region and re-aligns the half phase.
module vga_pixel_drive #(
  parameter logic        HSYNC_ACTIVE = 1'b1,
  parameter bit          HIGH_FIRST   = 1'b1,
  parameter logic [11:0] BLANK_VALUE  = 12'h000
) (
  input  logic        pixel_clk_2x,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic [23:0] pixel_data,
  output logic [11:0] vga_out
);

  logic        phase;
  logic [23:0] data_lat;
  logic        active;
  logic [11:0] first_half;
  logic [11:0] second_half;

  assign active = (hsync == HSYNC_ACTIVE);

  // First half comes from the live bus; second half only from the latched copy,
  // so pixel_data may change freely during phase 1.
  always_comb begin
    first_half  = HIGH_FIRST ? pixel_data[23:12] : pixel_data[11:0];
    second_half = HIGH_FIRST ? data_lat[11:0]    : data_lat[23:12];
  end

  always_ff @(posedge pixel_clk_2x or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 1'b0;
      data_lat <= '0;
      vga_out  <= BLANK_VALUE;
    end else if (!active) begin
      // Blanking wins over a pending second half; data_lat is left untouched.
      phase   <= 1'b0;
      vga_out <= BLANK_VALUE;
    end else if (!phase) begin
      data_lat <= pixel_data;
      vga_out  <= first_half;
      phase    <= 1'b1;
    end else begin
      vga_out <= second_half;
      phase   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_drive.sv
// Self-checking bench for vga_pixel_drive: queue-based reference model checked
// every cycle, directed line/blank/reset scenarios, then randomized traffic.
module tb_vga_pixel_drive;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b0;
  logic [23:0] pixel_data = '0;
  logic [11:0] vga_out;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  vga_pixel_drive #(
    .HSYNC_ACTIVE(1'b1),
    .HIGH_FIRST(1'b1),
    .BLANK_VALUE(12'h000)
  ) dut (
    .pixel_clk_2x(clk),
    .rst_n(rst_n),
    .hsync(hsync),
    .pixel_data(pixel_data),
    .vga_out(vga_out)
  );

  always #5 clk = ~clk;

  // Reference: a pixel becomes two queued half-words; an active edge pops one,
  // refilling from the live bus when empty. Blank or reset discards the queue.
  logic [11:0] exp_out = 12'h000;
  logic [11:0] pend[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      exp_out <= 12'h000;
    end else if (hsync !== 1'b1) begin
      pend.delete();
      exp_out <= 12'h000;
    end else begin
      if (pend.size() == 0) begin
        pend.push_back(pixel_data[23:12]);
        pend.push_back(pixel_data[11:0]);
      end
      exp_out <= pend.pop_front();
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) chk("model", vga_out, exp_out);
  end

  initial begin
    // Reset asserted from time 0; check mid-cycle assertion too
    repeat (2) @(negedge clk);
    chk("reset_hold", vga_out, 12'h000);
    rst_n = 1'b1;
    hsync = 1'b1;
    pixel_data = 24'hFF00AA;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", vga_out, 12'h000);
    hsync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Blanking
    pixel_data = 24'hFF00AA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("blank", vga_out, 12'h000);
    end

    // Line start
    hsync = 1'b1;
    @(negedge clk); chk("line_first", vga_out, 12'hFF0);
    chk("model_pin", exp_out, 12'hFF0);
    @(negedge clk); chk("line_second", vga_out, 12'h0AA);
    @(negedge clk); chk("line_third", vga_out, 12'hFF0);

    // Capture stability: change bus during phase 1
    pixel_data = 24'h123456;
    @(negedge clk); chk("capture_hold", vga_out, 12'h0AA);
    @(negedge clk); chk("next_hi", vga_out, 12'h123);
    @(negedge clk); chk("next_lo", vga_out, 12'h456);
    chk("model_pin2", exp_out, 12'h456);

    // Mid-pixel blank and realign
    pixel_data = 24'hFF00AA;
    @(negedge clk); chk("pre_blank", vga_out, 12'hFF0);
    hsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_blank", vga_out, 12'h000);
    end
    hsync = 1'b1;
    @(negedge clk); chk("realign", vga_out, 12'hFF0);
    @(negedge clk); chk("realign_lo", vga_out, 12'h0AA);
    @(negedge clk); chk("realign_hi2", vga_out, 12'hFF0);

    // Reset mid-line during phase 1
    #2 rst_n = 1'b0;
    #1 chk("reset_midline", vga_out, 12'h000);
    @(negedge clk);
    chk("reset_midline_hold", vga_out, 12'h000);
    rst_n = 1'b1;
    @(negedge clk); chk("post_reset_hi", vga_out, 12'hFF0);
    @(negedge clk); chk("post_reset_lo", vga_out, 12'h0AA);

    // Randomized traffic with occasional blanks and async resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) hsync = ~hsync;
      pixel_data = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_reset", vga_out, 12'h000);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
